// File: rtl/led_pkg.sv
// Shared constants for the LED display path: nibble width, dark-anode pattern
// and default scan timing so the board top and benches agree.
package led_pkg;
    localparam int BCD_W        = 4;
    localparam int MAX_DIGITS   = 8;
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;
    localparam int SCAN_DIV_DEF = 50000;
    localparam int DEAD_DEF     = 500;
endpackage

// File: rtl/scan_tick.sv
// Free-running prescaler: count 0..DIV-1, flag the last cycle of each period
// and the leading DEAD cycles. Also usable as a debouncer sampling tick.
module scan_tick #(
    parameter int DIV  = led_pkg::SCAN_DIV_DEF,
    parameter int DEAD = led_pkg::DEAD_DEF,
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] cnt,
    output logic          tick,
    output logic          dead
);
    assign tick = (cnt == CW'(DIV - 1));
    assign dead = (DEAD > 0) && (int'(cnt) < DEAD);

    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/led_scan.sv
// Time-multiplexed scanner for a common-anode 7-segment display with
// frame-synchronous updates, leading-zero blanking and per-slot dead time.
module led_scan
    import led_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = SCAN_DIV_DEF,
    parameter int DEAD     = DEAD_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] digits_in,
    input  logic [DIGITS-1:0]       dp_in,
    input  logic                    blank_lz,
    output logic [BCD_W-1:0]        bcd,
    output logic                    dp,
    output logic [DIGITS-1:0]       an,
    output logic                    frame
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0]             cnt;
    logic                      tick;
    logic                      dead;
    logic [IW-1:0]             idx;
    logic                      last_digit;
    logic                      boundary;

    logic [BCD_W*DIGITS-1:0]   sh_dig,  disp_dig;
    logic [DIGITS-1:0]         sh_dp,   disp_dp;
    logic                      sh_blz,  disp_blz;
    logic                      pending;

    logic [DIGITS-1:0]         blank;
    logic                      above;

    scan_tick #(.DIV(SCAN_DIV), .DEAD(DEAD)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .cnt  (cnt),
        .tick (tick),
        .dead (dead)
    );

    assign last_digit = (idx == IW'(DIGITS - 1));
    assign boundary   = tick && last_digit;

    always_ff @(posedge clk) begin
        if (rst)       idx <= '0;
        else if (tick) idx <= last_digit ? '0 : idx + IW'(1);
    end

    // A load on the boundary cycle goes straight to display; it is the newest
    // value, so any older shadow contents are dropped with pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_dig   <= '0;
            sh_dp    <= '0;
            sh_blz   <= 1'b0;
            disp_dig <= '0;
            disp_dp  <= '0;
            disp_blz <= 1'b0;
            pending  <= 1'b0;
        end else if (load && boundary) begin
            disp_dig <= digits_in;
            disp_dp  <= dp_in;
            disp_blz <= blank_lz;
            pending  <= 1'b0;
        end else if (load) begin
            sh_dig   <= digits_in;
            sh_dp    <= dp_in;
            sh_blz   <= blank_lz;
            pending  <= 1'b1;
        end else if (boundary && pending) begin
            disp_dig <= sh_dig;
            disp_dp  <= sh_dp;
            disp_blz <= sh_blz;
            pending  <= 1'b0;
        end
    end

    // Blanking ripples down from the top digit until a nonzero nibble or lit dp.
    always_comb begin
        blank = '0;
        above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            blank[k] = disp_blz && above && !disp_dp[k]
                       && (disp_dig[BCD_W*k +: BCD_W] == '0);
            above    = blank[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd   <= '0;
            dp    <= 1'b0;
            an    <= AN_OFF[DIGITS-1:0];
            frame <= 1'b0;
        end else begin
            bcd   <= disp_dig[BCD_W*int'(idx) +: BCD_W];
            dp    <= disp_dp[idx];
            an    <= (dead || blank[idx]) ? AN_OFF[DIGITS-1:0]
                                          : ~(DIGITS'(1) << idx);
            frame <= (cnt == '0) && (idx == '0);
        end
    end
endmodule

// File: tb/tb_led_scan.sv
// Self-checking bench for led_scan: directed scenarios plus random loads/resets,
// every output cycle compared against a frame-phase reference model.
module tb_led_scan;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int DEAD     = 2;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  bcd;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: phase within the frame plus shadow/display values.
    int          ph = 0;
    logic [15:0] m_dig = '0, s_dig = '0;
    logic [3:0]  m_dp = '0,  s_dp = '0;
    logic        m_blz = 1'b0, s_blz = 1'b0, m_pend = 1'b0;

    led_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD(DEAD)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .bcd       (bcd),
        .dp        (dp),
        .an        (an),
        .frame     (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h phase=%0d", tag, obs, exp, ph);
        end
    endtask

    // Digit k is dark when blanking is on and it sits above the highest
    // digit that is nonzero or carries a lit dp (digit 0 always counts).
    function automatic bit lz_dark(int k);
        int top = 0;
        if (!m_blz || k == 0) return 1'b0;
        for (int j = 0; j < DIGITS; j++)
            if (((m_dig >> (4 * j)) & 16'hF) != 16'h0 || m_dp[j]) top = j;
        return k > top;
    endfunction

    task automatic step(input logic l, input logic [15:0] d, input logic [3:0] p,
                        input logic b, input logic r);
        logic [3:0] e_bcd, e_an;
        logic       e_dp, e_frame;
        int         k, c;
        load = l; digits_in = d; dp_in = p; blank_lz = b; rst = r;
        if (r) begin
            e_bcd = 4'h0; e_dp = 1'b0; e_an = 4'hF; e_frame = 1'b0;
        end else begin
            k = ph / SCAN_DIV;
            c = ph % SCAN_DIV;
            e_bcd   = 4'((m_dig >> (4 * k)) & 16'hF);
            e_dp    = m_dp[k];
            e_an    = (c < DEAD || lz_dark(k)) ? 4'hF : (4'hF & ~(4'd1 << k));
            e_frame = (ph == 0);
        end
        @(posedge clk);
        if (r) begin
            ph = 0; m_dig = '0; m_dp = '0; m_blz = 1'b0;
            s_dig = '0; s_dp = '0; s_blz = 1'b0; m_pend = 1'b0;
        end else begin
            if (l && ph == FRAME - 1) begin
                m_dig = d; m_dp = p; m_blz = b; m_pend = 1'b0;
            end else if (l) begin
                s_dig = d; s_dp = p; s_blz = b; m_pend = 1'b1;
            end else if (ph == FRAME - 1 && m_pend) begin
                m_dig = s_dig; m_dp = s_dp; m_blz = s_blz; m_pend = 1'b0;
            end
            ph = (ph + 1) % FRAME;
        end
        #1;
        chk("bcd",   8'(bcd),   8'(e_bcd));
        chk("dp",    8'(dp),    8'(e_dp));
        chk("an",    8'(an),    8'(e_an));
        chk("frame", 8'(frame), 8'(e_frame));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic wait_ph(input int target);
        while (ph != target) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic b);
        step(1'b1, d, p, b, 1'b0);
    endtask

    initial begin
        int   seen_one;
        int   gap;
        bit   got;

        // Reset held three cycles, then an all-zero frame and a bit more.
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
        idle(FRAME + 8);

        // Basic scan, no blanking, dp on digit 2.
        do_load(16'h1234, 4'b0100, 1'b0);
        idle(2 * FRAME);

        // Leading-zero blanking variants.
        do_load(16'h0050, 4'b0000, 1'b1);
        idle(2 * FRAME);
        do_load(16'h0000, 4'b0000, 1'b1);
        idle(2 * FRAME);
        do_load(16'h0005, 4'b0100, 1'b1);
        idle(2 * FRAME);

        // Mid-frame updates: last load wins, 1111 must never appear.
        wait_ph(SCAN_DIV + 3);
        do_load(16'h1111, 4'b0000, 1'b0);
        wait_ph(2 * SCAN_DIV + 3);
        do_load(16'h2222, 4'b0000, 1'b0);
        seen_one = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            idle(1);
            if (bcd == 4'h1 && an != 4'hF) seen_one++;
        end
        chk("no_1111_shown", 8'(seen_one), 8'd0);

        // Load exactly on the frame boundary cycle.
        wait_ph(FRAME - 1);
        do_load(16'h9876, 4'b0000, 1'b0);
        idle(2 * FRAME);

        // Reset for one cycle in the middle of slot 2.
        do_load(16'h1234, 4'b0000, 1'b0);
        idle(FRAME + 4);
        wait_ph(2 * SCAN_DIV + 3);
        step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        chk("frame_after_rst", 8'(frame), 8'd1);
        gap = 0; got = 1'b0;
        for (int i = 0; i < FRAME + 8 && !got; i++) begin
            idle(1);
            gap++;
            if (frame) got = 1'b1;
        end
        chk("frame_gap_after_rst", 8'(gap), 8'(FRAME));

        // Random loads, occasional reset (load during reset must be ignored).
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom),
                 1'($urandom), ($urandom_range(0, 199) == 0));
        end
        // Random loads forced onto the boundary cycle.
        for (int i = 0; i < 4; i++) begin
            wait_ph(FRAME - 1);
            do_load(16'($urandom), 4'($urandom), 1'($urandom));
            idle(FRAME + 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/led_scan.md
# led_scan

Time-multiplexed scanner for the common-anode 4-digit 7-segment display. Holds a packed BCD value plus per-digit decimal points, cycles through the digits at a fixed slot rate, and drives one digit's `bcd`/`dp` into the 7-segment decoder while enabling that digit's anode. It provides frame-synchronous updates with no tearing, leading-zero blanking, and a dead time between slots to suppress ghosting. It sits directly upstream of the segment decoder, fed by the reaction-timer counter/BCD logic.

## Interface
- `DIGITS`, 4: number of digits scanned; legal range 1..8.
- `SCAN_DIV`, 50000: clock cycles per digit slot (1 kHz per slot at 50 MHz); must be > `DEAD`+1.
- `DEAD`, 500: cycles at the start of each slot with all anodes off; 0 disables dead time.
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  one-cycle strobe; captures `digits_in`, `dp_in`, `blank_lz`.
- `digits_in`  in  4*DIGITS  packed BCD; digit 0 (least significant, rightmost) is in [3:0].
- `dp_in`  in  DIGITS  decimal point per digit, 1 = lit.
- `blank_lz`  in  1  leading-zero blanking enable.
- `bcd`  out  4  nibble for the decoder.
- `dp`  out  1  decimal point for the decoder, active-high; the decoder inverts it.
- `an`  out  DIGITS  anode enables, active-low; all-ones = display dark.
- `frame`  out  1  one-cycle pulse marking the first cycle of digit 0's slot.

## Operation
- **Prescaler `cnt`.** Counts 0..SCAN_DIV-1 and wraps. The slot ends on the cycle where `cnt`==SCAN_DIV-1.
- **Digit index `idx`.** Counts 0..DIGITS-1 and advances at slot end. After DIGITS-1 it wraps to 0.
- **Frame boundary.** The slot-end cycle with `idx`==DIGITS-1.
- **Shadow register.** On `load`, `digits_in`/`dp_in`/`blank_lz` are captured into the shadow register and `pending` is set. Repeated loads within a frame overwrite the shadow; the last load wins.
- **Display register.** At the frame boundary, if `pending`, the shadow copies into the display register and `pending` clears.
- **`load` on the boundary cycle.** `digits_in` bypasses the shadow straight into the display register and `pending` stays 0.
- **Leading-zero blanking** (when the display copy of `blank_lz`=1):
  - Digit k is blanked if its nibble==0, its dp==0, and every digit above k is blanked.
  - Digit 0 is never blanked.
  - A lit dp stops blanking at that digit and every digit below it.
- **Per-cycle output for the current `idx`.**
  - `bcd` = display nibble[idx] and `dp` = display dp[idx].
  - `an` = all-ones when `cnt` < DEAD or digit idx is blanked.
  - Otherwise `an` = all-ones with bit idx cleared.
- **Nibbles A–F** pass through unchanged; no range check.

## Timing
- All outputs are registered. Outputs in cycle t+1 reflect `cnt`/`idx`/display state at cycle t.
- Slot length is exactly SCAN_DIV cycles; frame length is DIGITS*SCAN_DIV cycles.
- Within each non-blanked slot, `an` is low for SCAN_DIV-DEAD cycles and high for DEAD cycles.
- `bcd`/`dp` change only at slot start, while `an` is all-ones whenever DEAD>0.
- `frame` is high together with the first output cycle of idx 0.
- Update latency: a `load` takes effect at the first digit-0 slot after the next frame boundary. Worst case is DIGITS*SCAN_DIV+1 cycles.
- **Reset** (also when asserted mid-operation), effective next edge:
  - `cnt`=0, `idx`=0, `pending`=0.
  - Shadow and display registers = 0, including `blank_lz`=0.
  - Outputs: `an`=all-ones, `bcd`=0, `dp`=0, `frame`=0.
  - After release, scanning restarts at digit 0 showing all zeros.
- `load` while `rst`=1 is ignored.

## Structure
- Shared package/header `led_pkg`:
  - `BCD_W`=4.
  - `AN_OFF`, the all-ones anode constant.
  - Default `SCAN_DIV`/`DEAD` values, so the board top and benches agree.
- Sub-module `scan_tick`: parameterised prescaler that outputs `cnt`, the slot-end pulse and the dead-window flag. It is reusable for the button debouncer's sampling tick.
- The blanking mask is combinational from the display register and is registered with the outputs.
- `led_scan` does not instantiate the decoder; the top level connects `bcd`/`dp` to it.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=8, DEAD=2.
- **Reset.** Hold `rst` 3 cycles -> `an`=1111, `bcd`=0, `dp`=0, `frame`=0. After release, each slot has 2 dead cycles (`an`=1111) then 6 cycles with `bcd`=0; the 6-cycle `an` patterns run 1110, 1101, 1011, 0111 in order.
- **Basic scan.** `load` 16'h1234, `dp_in`=0100, `blank_lz`=0 -> after the next boundary, slots show 4/1110, 3/1101, 2/1011 with `dp`=1, then 1/0111. `frame` pulses every 32 cycles.
- **Blanking.**
  - 16'h0050 with `blank_lz`=1 -> digits 3 and 2 keep `an`=1111 for the whole slot; digits 1 and 0 show 5 and 0.
  - 16'h0000 -> only digit 0 lit.
  - 16'h0005 with `dp_in`=0100 -> digit 3 dark, digit 2 shows 0 with `dp`.
- **Mid-frame update.** `load` 16'h1111 during slot 1, then 16'h2222 during slot 2 -> old value continues to the boundary, then 2222 is shown. 1111 is never displayed.
- **Boundary coincidence.** `load` 16'h9876 exactly on the boundary cycle -> the next digit-0 slot shows 6. `pending` stays 0.
- **Reset mid-slot.** Assert `rst` one cycle during slot 2 after loading 16'h1234 -> next cycle `an`=1111. Scanning restarts at digit 0 showing 0, and the next `frame` pulse is 32 cycles after reset release.
